spi_tx_buffered: RTL and testbench

Parametrised SPI peripheral (slave) transmitter that runs entirely in the system clock domain, with a transmit FIFO and all four SPI modes. It oversamples `spi_sck`/`spi_csn`/`spi_sdi` through synchronisers instead of clocking logic on `spi_sck`, so no clock-domain handshake is needed. It sits between the Wishbone-side register logic, which pushes words, and the SPI pins.

---
 rtl/spi_pkg.sv | 18 +
 rtl/sync_fifo.sv | 67 ++++++
 rtl/spi_tx_buffered.sv | 203 ++++++++++++++++++++
 tb/tb_spi_tx_buffered.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode encodings, transmitter FSM states, synchroniser depth.
package spi_pkg;

  // Modes are encoded as {CPOL, CPHA}.
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } spi_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered ready/level; DEPTH must be a power of two so
// the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     empty_o,
  output logic                     ready_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q, level_d;
  logic             ready_q;
  logic             push_ok, pop_ok;

  // When full, a pop frees a slot but ready_q stays low until the next cycle.
  assign push_ok = push_i && ready_q;
  assign pop_ok  = pop_i && (level_q != '0);

  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    level_d = level_q;
    if (push_ok && !pop_ok) begin
      level_d = level_q + 1'b1;
    end else if (!push_ok && pop_ok) begin
      level_d = level_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
      ready_q <= (level_d != LW'(DEPTH));
    end
  end

  // NOTE: storage is not reset; entries are only read after being written, and the
  // pointers/level carry the reset state.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign empty_o = (level_q == '0);
  assign ready_o = ready_q;
  assign level_o = level_q;

endmodule

// File: rtl/spi_tx_buffered.sv
// Oversampled SPI peripheral transmitter with TX FIFO, all four modes.
// Define SPI_TX_BUFFERED_RX_EN to add the receive shifter and rx_data/rx_valid ports.
module spi_tx_buffered
  import spi_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter bit               CPOL      = 1'b0,
  parameter bit               CPHA      = 1'b0,
  parameter logic [WIDTH-1:0] IDLE_WORD = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   spi_sck,
  input  logic                   spi_csn,
  input  logic                   spi_sdi,
  output logic                   spi_sdo,
  input  logic [WIDTH-1:0]       tx_data,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  output logic [$clog2(DEPTH):0] tx_level,
  output logic                   underrun,
  input  logic                   underrun_clr
`ifdef SPI_TX_BUFFERED_RX_EN
  ,
  output logic [WIDTH-1:0]       rx_data,
  output logic                   rx_valid
`endif
);

  localparam int         CW            = $clog2(WIDTH);
  localparam logic [1:0] MODE          = {CPOL, CPHA};
  localparam bit         SAMPLE_ON_LEAD = (MODE == SPI_MODE0) || (MODE == SPI_MODE2);
  localparam bit         SHIFT_ON_LEAD  = (MODE == SPI_MODE1) || (MODE == SPI_MODE3);

  logic [SYNC_STAGES-1:0] sck_sync_q, csn_sync_q;
  logic                   sck_s, csn_s;
  logic                   sck_prev_q, csn_prev_q;
  logic                   lead_q, trail_q, csn_fall_q, csn_rise_q;
  logic                   sample_edge, shift_edge;

  spi_state_e       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sampled_q, sampled_d;
  logic             underrun_q, underrun_d;

  logic             push, pop;
  logic [WIDTH-1:0] fifo_rdata;
  logic             fifo_empty;

  assign sck_s = sck_sync_q[SYNC_STAGES-1];
  assign csn_s = csn_sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync_q <= {SYNC_STAGES{CPOL}};
      csn_sync_q <= '1;
      sck_prev_q <= CPOL;
      csn_prev_q <= 1'b1;
      lead_q     <= 1'b0;
      trail_q    <= 1'b0;
      csn_fall_q <= 1'b0;
      csn_rise_q <= 1'b0;
    end else begin
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      csn_sync_q <= {csn_sync_q[SYNC_STAGES-2:0], spi_csn};
      sck_prev_q <= sck_s;
      csn_prev_q <= csn_s;
      lead_q     <= (sck_prev_q == CPOL) && (sck_s != CPOL);
      trail_q    <= (sck_prev_q != CPOL) && (sck_s == CPOL);
      csn_fall_q <= csn_prev_q && !csn_s;
      csn_rise_q <= !csn_prev_q && csn_s;
    end
  end

  assign sample_edge = SAMPLE_ON_LEAD ? lead_q : trail_q;
  assign shift_edge  = SHIFT_ON_LEAD  ? lead_q : trail_q;

  // A shift edge before the first sample of a word is skipped: the MSB is already
  // on spi_sdo (CPHA=1 leading edge, or CPHA=0 trailing edge at a word boundary).
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    cnt_d      = cnt_q;
    sampled_d  = sampled_q;
    underrun_d = underrun_q && !underrun_clr;
    pop        = 1'b0;
    if (csn_rise_q) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (csn_fall_q) state_d = LOAD;
        end
        LOAD: begin
          if (fifo_empty) begin
            shreg_d    = IDLE_WORD;
            underrun_d = 1'b1;
          end else begin
            shreg_d = fifo_rdata;
            pop     = 1'b1;
          end
          cnt_d     = CW'(WIDTH - 1);
          sampled_d = 1'b0;
          state_d   = SHIFT;
        end
        SHIFT: begin
          if (shift_edge && sampled_q) shreg_d = shreg_q << 1;
          if (sample_edge) begin
            sampled_d = 1'b1;
            cnt_d     = cnt_q - 1'b1;
            if (cnt_q == '0) state_d = LOAD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      cnt_q      <= '0;
      sampled_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      sampled_q  <= sampled_d;
      underrun_q <= underrun_d;
    end
  end

  assign push     = tx_valid && tx_ready;
  assign spi_sdo  = shreg_q[WIDTH-1];
  assign underrun = underrun_q;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (tx_data),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .ready_o (tx_ready),
    .level_o (tx_level)
  );

`ifdef SPI_TX_BUFFERED_RX_EN
  logic [SYNC_STAGES-1:0] sdi_sync_q;
  logic                   sdi_q;
  logic [WIDTH-1:0]       rx_shift_q, rx_shift_d;
  logic [WIDTH-1:0]       rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   rx_take;

  // sdi_q is delayed to line up with the registered edge flags.
  assign rx_take = (state_q == SHIFT) && sample_edge && !csn_rise_q;

  always_comb begin
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    if (rx_take) begin
      rx_shift_d = {rx_shift_q[WIDTH-2:0], sdi_q};
      if (cnt_q == '0) begin
        rx_data_d  = {rx_shift_q[WIDTH-2:0], sdi_q};
        rx_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sdi_sync_q <= '0;
      sdi_q      <= 1'b0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], spi_sdi};
      sdi_q      <= sdi_sync_q[SYNC_STAGES-1];
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
`else
  logic unused_sdi;
  assign unused_sdi = spi_sdi;
`endif

endmodule

// File: tb/tb_spi_tx_buffered.sv
// Directed bench: mode 0 / WIDTH 8 and mode 3 / WIDTH 16 instances driven as an SPI controller.
module tb_spi_tx_buffered;

  localparam int HALF = 8;

  logic clk;
  logic rst;

  logic        sck0, csn0, sdi0, sdo0;
  logic [7:0]  tx_data0;
  logic        tx_valid0, tx_ready0;
  logic [2:0]  tx_level0;
  logic        underrun0, underrun_clr0;

  logic        sck3, csn3, sdi3, sdo3;
  logic [15:0] tx_data3;
  logic        tx_valid3, tx_ready3;
  logic [2:0]  tx_level3;
  logic        underrun3, underrun_clr3;

`ifdef SPI_TX_BUFFERED_RX_EN
  logic [7:0]  rx_data0;
  logic        rx_valid0;
  logic [15:0] rx_data3;
  logic        rx_valid3;
  int          rx_cnt3 = 0;
  logic [15:0] rx_last3 = '0;
`endif

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] w;
  logic        so;
  logic        seen;
  logic [15:0] pat;

  spi_tx_buffered #(
    .WIDTH(8), .DEPTH(4), .CPOL(1'b0), .CPHA(1'b0), .IDLE_WORD(8'hFF)
  ) dut0 (
    .clk          (clk),
    .rst          (rst),
    .spi_sck      (sck0),
    .spi_csn      (csn0),
    .spi_sdi      (sdi0),
    .spi_sdo      (sdo0),
    .tx_data      (tx_data0),
    .tx_valid     (tx_valid0),
    .tx_ready     (tx_ready0),
    .tx_level     (tx_level0),
    .underrun     (underrun0),
    .underrun_clr (underrun_clr0)
`ifdef SPI_TX_BUFFERED_RX_EN
    ,
    .rx_data      (rx_data0),
    .rx_valid     (rx_valid0)
`endif
  );

  spi_tx_buffered #(
    .WIDTH(16), .DEPTH(4), .CPOL(1'b1), .CPHA(1'b1), .IDLE_WORD(16'h0000)
  ) dut3 (
    .clk          (clk),
    .rst          (rst),
    .spi_sck      (sck3),
    .spi_csn      (csn3),
    .spi_sdi      (sdi3),
    .spi_sdo      (sdo3),
    .tx_data      (tx_data3),
    .tx_valid     (tx_valid3),
    .tx_ready     (tx_ready3),
    .tx_level     (tx_level3),
    .underrun     (underrun3),
    .underrun_clr (underrun_clr3)
`ifdef SPI_TX_BUFFERED_RX_EN
    ,
    .rx_data      (rx_data3),
    .rx_valid     (rx_valid3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SPI_TX_BUFFERED_RX_EN
  always @(negedge clk) begin
    if (rx_valid3) begin
      rx_cnt3  = rx_cnt3 + 1;
      rx_last3 = rx_data3;
    end
  end
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push0(input logic [7:0] d);
    tx_valid0 = 1'b1;
    tx_data0  = d;
    @(negedge clk);
    tx_valid0 = 1'b0;
  endtask

  task automatic push3(input logic [15:0] d);
    tx_valid3 = 1'b1;
    tx_data3  = d;
    @(negedge clk);
    tx_valid3 = 1'b0;
  endtask

  // Mode 0 bit: data set, controller samples sdo at the rising edge, falls afterwards.
  task automatic bit0(input logic b, output logic s);
    sdi0 = b;
    repeat (HALF) @(negedge clk);
    s    = sdo0;
    sck0 = 1'b1;
    repeat (HALF) @(negedge clk);
    sck0 = 1'b0;
  endtask

  // Mode 3 bit: falling (leading) edge, then controller samples sdo at the rising edge.
  task automatic bit3(input logic b, output logic s);
    sck3 = 1'b0;
    sdi3 = b;
    repeat (HALF) @(negedge clk);
    s    = sdo3;
    sck3 = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    sck0 = 1'b0; csn0 = 1'b1; sdi0 = 1'b0; tx_data0 = '0; tx_valid0 = 1'b0; underrun_clr0 = 1'b0;
    sck3 = 1'b1; csn3 = 1'b1; sdi3 = 1'b0; tx_data3 = '0; tx_valid3 = 1'b0; underrun_clr3 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("reset_sdo0",      sdo0,      0);
    check("reset_ready0",    tx_ready0, 1);
    check("reset_level0",    tx_level0, 0);
    check("reset_underrun0", underrun0, 0);
    check("reset_sdo3",      sdo3,      0);
    check("reset_ready3",    tx_ready3, 1);
`ifdef SPI_TX_BUFFERED_RX_EN
    check("reset_rx_valid3", rx_valid3, 0);
    check("reset_rx_data3",  rx_data3,  0);
`endif

    // Mode 0: two queued words, then an empty FIFO yields the idle word.
    push0(8'hA5);
    push0(8'h3C);
    @(negedge clk);
    check("level_two", tx_level0, 2);
    csn0 = 1'b0;
    repeat (HALF) @(negedge clk);
    w = '0;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check("no_underrun_mid", underrun0, 0);
      bit0(1'b0, so);
      w = {w[30:0], so};
    end
    check("mode0_words", w, 32'h0000A53C);
    w = '0;
    for (int i = 0; i < 8; i++) begin
      bit0(1'b0, so);
      w = {w[30:0], so};
    end
    check("idle_word", w, 32'h000000FF);
    check("underrun_set", underrun0, 1);
    csn0 = 1'b1;
    repeat (HALF) @(negedge clk);
    underrun_clr0 = 1'b1;
    @(negedge clk);
    underrun_clr0 = 1'b0;
    @(negedge clk);
    check("underrun_clr", underrun0, 0);
    check("level_empty", tx_level0, 0);

    // Mode 3, 16-bit word out while 0xBEEF comes in.
    pat = 16'hBEEF;
    push3(16'h1234);
    csn3 = 1'b0;
    repeat (HALF) @(negedge clk);
    w = '0;
    for (int i = 15; i >= 0; i--) begin
      bit3(pat[i], so);
      w = {w[30:0], so};
    end
    check("mode3_word", w, 32'h00001234);
    repeat (HALF) @(negedge clk);
`ifdef SPI_TX_BUFFERED_RX_EN
    check("rx_pulses", rx_cnt3, 1);
    check("rx_data",   rx_last3, 16'hBEEF);
`endif
    check("underrun3_set", underrun3, 1);
    csn3 = 1'b1;

    // Full FIFO, then a push offered across the pop cycle.
    push0(8'h81);
    push0(8'h42);
    push0(8'h18);
    push0(8'hE7);
    @(negedge clk);
    check("full_ready", tx_ready0, 0);
    check("full_level", tx_level0, 4);
    csn0      = 1'b0;
    tx_data0  = 8'h99;
    tx_valid0 = 1'b1;
    seen      = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (tx_level0 != 3'd4) seen = 1'b1;
    end
    tx_valid0 = 1'b0;
    check("pop_seen",        seen,      1);
    check("level_after_pop", tx_level0, 3);
    check("ready_after_pop", tx_ready0, 1);
    @(negedge clk);
    check("push_rejected",   tx_level0, 3);

    // Abort 0x81 after 3 bits; the next selection sends 0x42.
    w = '0;
    for (int i = 0; i < 3; i++) begin
      bit0(1'b0, so);
      w = {w[30:0], so};
    end
    check("abort_bits", w, 32'h4);
    csn0 = 1'b1;
    repeat (HALF) @(negedge clk);
    csn0 = 1'b0;
    repeat (HALF) @(negedge clk);
    w = '0;
    for (int i = 0; i < 8; i++) begin
      bit0(1'b0, so);
      w = {w[30:0], so};
    end
    check("after_abort_word", w, 32'h42);
    check("level_after_word", tx_level0, 1);
    csn0 = 1'b1;
    repeat (HALF) @(negedge clk);

    // Asynchronous reset in the middle of 0xE7 with one entry still queued.
    push0(8'h11);
    csn0 = 1'b0;
    repeat (HALF) @(negedge clk);
    w = '0;
    for (int i = 0; i < 2; i++) begin
      bit0(1'b0, so);
      w = {w[30:0], so};
    end
    check("e7_bits", w, 32'h3);
    repeat (HALF) @(negedge clk);
    check("sdo_mid_word",   sdo0,      1);
    check("level_pre_rst",  tx_level0, 1);
    #2 rst = 1'b1;
    #1;
    check("rst_sdo0",       sdo0,      0);
    check("rst_ready0",     tx_ready0, 1);
    check("rst_level0",     tx_level0, 0);
    check("rst_underrun0",  underrun0, 0);
    check("rst_underrun3",  underrun3, 0);
    @(negedge clk);
    rst  = 1'b0;
    csn0 = 1'b1;
    @(negedge clk);
    check("post_rst_level", tx_level0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
